// File: rtl/instr_sequencer_if.sv
// Sequencer-side bus: fetch/data memory handshakes, ALU flags and control outputs.
// master = sequencer, slave = memory/datapath environment.
interface instr_sequencer_if;
  logic        RUN;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [15:0] INSTR;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic        DMEM_ACK;
  logic [3:0]  FLAGS;
  logic [15:0] PC;
  logic [15:0] EXEC;
  logic [3:0]  S_ALU;
  logic        REG_WE;
  logic [2:0]  PHASE;
  logic        HALTED;

  modport master (
    input  RUN, IMEM_ACK, INSTR, DMEM_ACK, FLAGS,
    output IMEM_REQ, DMEM_REQ, DMEM_WE, PC, EXEC, S_ALU, REG_WE, PHASE, HALTED
  );

  modport slave (
    output RUN, IMEM_ACK, INSTR, DMEM_ACK, FLAGS,
    input  IMEM_REQ, DMEM_REQ, DMEM_WE, PC, EXEC, S_ALU, REG_WE, PHASE, HALTED
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; memory waits stretch FETCH/MEM via REQ held until ACK.
// Optional ILLEGAL_TRAP_EN: unknown op2 subcodes halt instead of executing as a NOP.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic            CLOCK,
  input logic            RESET,
  instr_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] exec_q, exec_d;

  logic [1:0]  opc;
  logic [2:0]  sub;
  logic [15:0] br_target;
  logic        sv;
  logic        cond_taken;
  logic        halt_op;
  state_t      boundary_st;
  logic        unused_carry;

  assign unused_carry = bus.FLAGS[1];

  always_comb begin
    opc         = exec_q[15:14];
    sub         = exec_q[13:11];
    // PC has already been incremented past this instruction when the offset is applied.
    br_target   = pc_q + {{8{exec_q[7]}}, exec_q[7:0]};
    sv          = bus.FLAGS[3] ^ bus.FLAGS[0];
    boundary_st = bus.RUN ? ST_FETCH : ST_IDLE;
    case (exec_q[10:8])
      3'b000:  cond_taken = bus.FLAGS[2];
      3'b001:  cond_taken = sv;
      3'b010:  cond_taken = bus.FLAGS[2] | sv;
      3'b011:  cond_taken = ~bus.FLAGS[2];
      default: cond_taken = 1'b0;
    endcase
`ifdef ILLEGAL_TRAP_EN
    halt_op = ((opc == 2'b11) && (exec_q[7:4] == 4'hF)) ||
              ((opc == 2'b10) && (sub != 3'b000) && (sub != 3'b100) && (sub != 3'b111));
`else
    halt_op = (opc == 2'b11) && (exec_q[7:4] == 4'hF);
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    exec_d  = exec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.RUN) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.IMEM_ACK) begin
          exec_d  = bus.INSTR;
          pc_d    = pc_q + 16'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = halt_op ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        unique case (opc)
          2'b11:        state_d = ST_WB;
          2'b00, 2'b01: state_d = ST_MEM;
          2'b10: begin
            case (sub)
              3'b000: state_d = ST_WB;
              3'b100: begin
                pc_d    = br_target;
                state_d = boundary_st;
              end
              3'b111: begin
                if (cond_taken) pc_d = br_target;
                state_d = boundary_st;
              end
              default: state_d = boundary_st;
            endcase
          end
        endcase
      end
      ST_MEM: begin
        if (bus.DMEM_ACK) state_d = (opc == 2'b01) ? boundary_st : ST_WB;
      end
      ST_WB:   state_d = boundary_st;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      exec_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      exec_q  <= exec_d;
    end
  end

  // Every output is a decode of registered state, so no input reaches an output combinationally.
  assign bus.IMEM_REQ = (state_q == ST_FETCH);
  assign bus.DMEM_REQ = (state_q == ST_MEM);
  assign bus.DMEM_WE  = (state_q == ST_MEM) && (opc == 2'b01);
  assign bus.REG_WE   = (state_q == ST_WB);
  assign bus.HALTED   = (state_q == ST_HALT);
  assign bus.PHASE    = state_q;
  assign bus.PC       = pc_q;
  assign bus.EXEC     = exec_q;
  assign bus.S_ALU    = (opc == 2'b11) ? exec_q[7:4] : 4'h0;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a responder plays memory, a model predicts each instruction's outcome.
module tb_instr_sequencer;
  localparam logic [15:0] RPC = 16'h0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if bus();
  instr_sequencer #(.RESET_PC(RPC)) dut (.CLOCK(clk), .RESET(rst), .bus(bus));

  typedef struct {
    logic [15:0] word;
    int          iw;
    int          dw;
    logic [3:0]  flags;
  } stim_t;

  typedef struct {
    logic [15:0] word;
    logic [15:0] pc;
    int          cyc;
    int          regwe;
    int          dcyc;
    bit          dwe;
    logic [3:0]  salu;
    bit          halt;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          retired = 0;
  int          run_mode = 0;   // 0 low, 1 high, 2 random
  logic [15:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Predicts one instruction from its class: phase count, strobes and resulting PC.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [1:0] cls;
    logic [2:0] sub;
    bit z, svx, taken;
    int off;
    cls = s.word[15:14];
    sub = s.word[13:11];
    z   = s.flags[2];
    svx = s.flags[3] ^ s.flags[0];
    off = $signed(s.word[7:0]);
    taken = 0;
    e.word = s.word; e.halt = 0; e.regwe = 0; e.dcyc = 0; e.dwe = 0; e.salu = 4'h0; e.cyc = 0;
    m_pc = m_pc + 16'd1;
    case (cls)
      2'b11: begin
        if (s.word[7:4] == 4'hF) begin e.halt = 1; e.cyc = s.iw + 2; end
        else begin e.cyc = s.iw + 4; e.regwe = 1; e.salu = s.word[7:4]; end
      end
      2'b00: begin e.cyc = s.iw + 5 + s.dw; e.regwe = 1; e.dcyc = s.dw + 1; end
      2'b01: begin e.cyc = s.iw + 4 + s.dw; e.dcyc = s.dw + 1; e.dwe = 1; end
      default: begin
        if (sub == 3'd0) begin e.cyc = s.iw + 4; e.regwe = 1; end
        else if (sub == 3'd4) begin e.cyc = s.iw + 3; taken = 1; end
        else if (sub == 3'd7) begin
          e.cyc = s.iw + 3;
          case (s.word[10:8])
            3'd0: taken = z;
            3'd1: taken = svx;
            3'd2: taken = z || svx;
            3'd3: taken = !z;
            default: taken = 0;
          endcase
        end else begin
`ifdef ILLEGAL_TRAP_EN
          e.halt = 1; e.cyc = s.iw + 2;
`else
          e.cyc = s.iw + 3;
`endif
        end
      end
    endcase
    if (taken) m_pc = 16'(32'(m_pc) + off);
    e.pc = m_pc;
    return e;
  endfunction

  // Memory responder / RUN driver; stray ACKs are thrown in whenever REQ is low.
  initial begin
    stim_t cur;
    bit have_cur = 0, d_active = 0;
    int i_cnt = 0, d_cnt = 0, cur_dw = 0;
    bus.RUN = 0; bus.IMEM_ACK = 0; bus.DMEM_ACK = 0; bus.INSTR = 0; bus.FLAGS = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur = 0; d_active = 0; m_pc = RPC;
        bus.RUN = 0; bus.IMEM_ACK = 0; bus.DMEM_ACK = 0;
        stim_q.delete(); exp_q.delete();
      end else begin
        bus.RUN = (run_mode == 1) || (run_mode == 2 && $urandom_range(0, 7) != 0);
        if (bus.IMEM_REQ) begin
          if (!have_cur && stim_q.size() > 0) begin
            cur = stim_q.pop_front(); have_cur = 1; i_cnt = cur.iw;
            exp_q.push_back(model(cur));
          end
          if (have_cur && i_cnt == 0) begin
            bus.IMEM_ACK = 1; bus.INSTR = cur.word; bus.FLAGS = cur.flags;
            cur_dw = cur.dw; have_cur = 0;
          end else begin
            if (have_cur) i_cnt--;
            bus.IMEM_ACK = 0; bus.INSTR = 16'($urandom);
          end
        end else begin
          bus.IMEM_ACK = 1'($urandom_range(0, 1)); bus.INSTR = 16'($urandom);
        end
        if (bus.DMEM_REQ) begin
          if (!d_active) begin d_active = 1; d_cnt = cur_dw; end
          if (d_cnt == 0) begin bus.DMEM_ACK = 1; d_active = 0; end
          else begin d_cnt--; bus.DMEM_ACK = 0; end
        end else begin
          bus.DMEM_ACK = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: accumulates what one instruction did and scores it when it leaves its last phase.
  initial begin
    int p, prev, cyc, rw, dc;
    bit dwe;
    logic [3:0] sa;
    exp_t e;
    prev = 0; cyc = 0; rw = 0; dc = 0; dwe = 0; sa = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev = 0; cyc = 0; rw = 0; dc = 0; dwe = 0; sa = 0;
      end else begin
        p = int'(bus.PHASE);
        if (prev >= 2 && prev <= 5 && (p <= 1 || p == 6)) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: instruction retired with no prediction at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("exec", bus.EXEC, e.word);
            chk("pc", bus.PC, e.pc);
            chk("cycles", cyc, e.cyc);
            chk("reg_we", rw, e.regwe);
            chk("dmem_cyc", dc, e.dcyc);
            chk("dmem_we", dwe, e.dwe);
            chk("s_alu", sa, e.salu);
            chk("halted", p == 6, e.halt);
            if (!e.halt) chk("next_phase", p, bus.RUN ? 1 : 0);
            retired++;
          end
          cyc = 0; rw = 0; dc = 0; dwe = 0; sa = 0;
        end
        if (p >= 1 && p <= 5) begin
          cyc++;
          rw += int'(bus.REG_WE);
          dc += int'(bus.DMEM_REQ);
          if (bus.DMEM_REQ && bus.DMEM_WE) dwe = 1;
          if (p == 3) sa = bus.S_ALU;
        end
        prev = p;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1; run_mode = 0;
    @(posedge clk); #2;
    chk("rst_phase", bus.PHASE, 0);
    chk("rst_pc", bus.PC, RPC);
    chk("rst_exec", bus.EXEC, 0);
    chk("rst_outs", {bus.IMEM_REQ, bus.DMEM_REQ, bus.DMEM_WE, bus.REG_WE, bus.HALTED, bus.S_ALU}, 0);
    @(negedge clk); #1;
    rst = 0;
  endtask

  task automatic push(input logic [15:0] w, input int iw, input int dw, input logic [3:0] f);
    stim_t s;
    s.word = w; s.iw = iw; s.dw = dw; s.flags = f;
    stim_q.push_back(s);
  endtask

  task automatic run_seg(input int n, input int mode);
    int base, t;
    base = retired; t = 0;
    run_mode = mode;
    while (retired < base + n && !bus.HALTED && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("seg_done", t < 3000, 1);
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    logic [15:0] w;
    logic [2:0] il;
    int k;
    k = $urandom_range(0, 9);
    w = 16'($urandom);
    case (k)
      0, 1: begin w[15:14] = 2'b11; if (w[7:4] == 4'hF) w[7:4] = 4'hE; end
      2, 3: w[15:14] = 2'b00;
      4:    w[15:14] = 2'b01;
      5:    w[15:11] = 5'b10000;
      6:    w[15:11] = 5'b10100;
      7, 8: w[15:11] = 5'b10111;
      default: begin
        il = 3'($urandom_range(1, 6));
        if (il == 3'd4) il = 3'd3;
        w[15:11] = {2'b10, il};
      end
    endcase
    s.word  = w;
    s.iw    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    s.dw    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    s.flags = 4'($urandom);
    return s;
  endfunction

  initial begin
    int t;
    do_reset();

    push(16'hC030, 0, 0, 4'h0);
    run_seg(1, 1);
    do_reset();

    push(16'h0123, 0, 3, 4'h0);
    push(16'h4567, 1, 1, 4'h0);
    push(16'h0F00, 2, 0, 4'h0);
    run_seg(3, 1);
    do_reset();

    // Reach PC 0x20, then the conditional branch both ways, then every condition/flag mix.
    push(16'hA00F, 0, 0, 4'h0);
    push(16'hB8FE, 0, 0, 4'b0100);
    push(16'hB8FE, 0, 0, 4'b0000);
    for (int c = 0; c < 4; c++)
      for (int f = 0; f < 8; f++)
        push({5'b10111, 3'(c), 8'h02}, 0, 0, {f[2], f[1], 1'b0, f[0]});
    run_seg(35, 1);
    do_reset();

    push(16'hA080, 0, 0, 4'h0);
    push(16'hA05E, 0, 0, 4'h0);
    push(16'hA07F, 0, 0, 4'h0);
    push(16'hC030, 0, 0, 4'h0);
    run_seg(4, 1);
    do_reset();

    push(16'h0ABC, 0, 5, 4'h0);
    run_mode = 1;
    t = 0;
    while (bus.PHASE != 3'd4 && t < 100) begin @(posedge clk); #2; t++; end
    chk("reach_mem", bus.PHASE, 4);
    run_mode = 0;
    t = 0;
    while (retired < 1 + 0 && t < 0) t++;
    t = 0;
    while (bus.PHASE != 3'd0 && t < 100) begin @(posedge clk); #2; t++; end
    repeat (3) @(posedge clk); #2;
    chk("idle_after_drop", bus.PHASE, 0);
    push(16'hC010, 0, 0, 4'h0);
    run_seg(1, 1);

    do_reset();
    push(16'hC030, 8, 0, 4'h0);
    run_mode = 1;
    t = 0;
    while (!bus.IMEM_REQ && t < 100) begin @(posedge clk); #2; t++; end
    chk("fetch_wait", bus.IMEM_REQ, 1);
    repeat (2) @(posedge clk);
    do_reset();

    push(16'hC030, 0, 0, 4'h0);
    push(16'hC0F0, 1, 0, 4'h0);
    run_seg(2, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("halt_hold", {bus.HALTED, bus.PHASE, bus.IMEM_REQ}, {1'b1, 3'd6, 1'b0});
    end
    do_reset();

    push(16'h8812, 0, 0, 4'h0);
    push(16'hC030, 0, 0, 4'h0);
    run_seg(2, 1);
    do_reset();

    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 40; i++) stim_q.push_back(rnd_stim());
      run_seg(40, 2);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the 16-bit core. It fetches each instruction word, latches it, and steps the datapath through decode, execute, memory and write-back phases according to the instruction class. It drives the program counter, the ALU select and the memory and register-file strobes, and sits between instruction/data memory and the ALU/register file.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RUN  in  1  enables sequencing; sampled in IDLE and at instruction boundaries.
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ACK  in  1  fetch complete; INSTR is valid in the same cycle.
- INSTR  in  16  instruction word from instruction memory.
- DMEM_REQ  out  1  data memory request.
- DMEM_WE  out  1  1 = store, 0 = load; valid while DMEM_REQ=1.
- DMEM_ACK  in  1  data access complete.
- FLAGS  in  4  ALU flags {S,Z,C,V} from the last ALU operation.
- PC  out  16  program counter.
- EXEC  out  16  latched instruction register.
- S_ALU  out  4  ALU select: EXEC[7:4] for op3, otherwise 4'h0.
- REG_WE  out  1  register-file write strobe, one cycle.
- PHASE  out  3  current state encoding.
- HALTED  out  1  high in HALT.

## Operation
- States and PHASE codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: if RUN=1, go to FETCH.
- FETCH: IMEM_REQ=1 until IMEM_ACK. On the ACK cycle: EXEC<=INSTR, PC<=PC+1 (mod 2^16), go to DECODE.
- DECODE: lasts one cycle, then go to EXEC. The HALT check happens here: op3 with EXEC[7:4]=4'hF goes to HALT instead of EXEC.
- EXEC: lasts one cycle. Next state depends on EXEC[15:14]:
  - 11 (op3, ALU): go to WB.
  - 00 (load) and 01 (store): go to MEM.
  - 10 (op2), by EXEC[13:11]:
    - 000 (load immediate): go to WB.
    - 100 (branch): PC<=PC+sext(EXEC[7:0]), then go to boundary.
    - 111 (conditional branch), by EXEC[10:8]: 000 taken if Z; 001 if S^V; 010 if Z|(S^V); 011 if !Z; other codes never taken. If taken, update PC as for 100. Then go to boundary.
- MEM: DMEM_REQ=1 and DMEM_WE=(EXEC[15:14]==01) until DMEM_ACK. On ACK, a load goes to WB and a store goes to boundary.
- WB: REG_WE=1 for exactly one cycle, then go to boundary.
- Boundary: go to FETCH if RUN=1, otherwise IDLE. Deasserting RUN never aborts an instruction in progress.
- HALT: absorbing; only RESET leaves it.
- IMEM_ACK/DMEM_ACK are ignored whenever the matching REQ is 0.
- Branch arithmetic uses the already-incremented PC, 16-bit wrap, 8-bit offset sign-extended.

## Timing
- Reset values: PC=RESET_PC, EXEC=0, state IDLE, PHASE=0, and all strobes, S_ALU and HALTED 0.
- RESET asserted mid-FETCH or mid-MEM: REQ is 0 in the cycle after the edge, and the pending ACK is discarded.
- Zero-wait latencies, from FETCH entry to the next FETCH entry:
  - ALU: 4 cycles.
  - load immediate: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch: 3 cycles.
- Each memory wait cycle adds one cycle.
- S_ALU is valid during EXEC and WB. FLAGS is sampled in EXEC.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.

## Configuration
- ILLEGAL_TRAP_EN defined: op2 subcodes other than 000/100/111 go from DECODE to HALT, and HALTED=1.
- ILLEGAL_TRAP_EN undefined: those subcodes execute as a NOP (DECODE→EXEC→boundary, no strobes).

## Test plan
- Reset with RESET_PC=16'h0010, RUN=1, zero-wait ALU instruction 16'hC030 -> PHASE sequence 1,2,3,5,1; S_ALU=4'h3 in EXEC; one REG_WE pulse; PC=16'h0011.
- Load with DMEM_ACK delayed 3 cycles -> DMEM_REQ=1 for 4 cycles with DMEM_WE=0; REG_WE pulses once after the ACK. Store -> no REG_WE.
- Conditional branch 16'hB8FE (cond 000, offset -2) at PC=16'h0020: with Z=1 the next PC is 16'h001F; with Z=0 it is 16'h0021. Cover all four conditions with both S^V polarities.
- Unconditional branch with offset 8'h7F at PC=16'hFFF0 -> PC wraps to 16'h0070.
- RUN dropped during MEM -> the instruction completes and the sequencer goes to IDLE. RESET during a FETCH wait -> IMEM_REQ=0 on the next cycle and PC=RESET_PC.
- Op3 func 4'hF -> HALTED=1, held across 10 cycles. Op2 subcode 001 -> HALT with ILLEGAL_TRAP_EN defined; NOP (3 cycles, PC+1) without it.
